// File: rtl/if_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package if_fetch_pkg;

   localparam int INST_ADDR_W = 32;
   localparam int INST_W      = 32;
   localparam int BYTE_W      = 8;

   typedef logic [INST_ADDR_W-1:0] inst_addr_t;
   typedef logic [INST_W-1:0]      inst_t;
   typedef logic [BYTE_W-1:0]      byte_t;

   localparam logic  RST_ENABLE = 1'b1;
   localparam logic  STOP       = 1'b1;
   localparam logic  NO_STOP    = 1'b0;
   localparam inst_t ZERO_WORD  = 32'h0000_0000;

   localparam logic [2:0] BYTES_PER_INST = 3'd4;

   typedef enum logic {
      FETCH = 1'b0,
      HOLD  = 1'b1
   } fetch_state_t;

endpackage

// File: rtl/if_fetch_mem_if.sv
// Byte-wide read port between the fetch stage and the memory controller.
interface if_fetch_mem_if;
   import if_fetch_pkg::*;

   logic       if_mem_req;
   inst_addr_t if_mem_addr;
   logic       mem_if_grant;
   byte_t      mem_if_data;

   modport master (
      output if_mem_req,
      output if_mem_addr,
      input  mem_if_grant,
      input  mem_if_data
   );

   modport slave (
      input  if_mem_req,
      input  if_mem_addr,
      output mem_if_grant,
      output mem_if_data
   );

endinterface

// File: rtl/if_fetch.sv
// Instruction fetch: owns the PC, assembles each instruction from four byte
// reads and hands it to if_id under the get_inst / stall[0] handshake.
//
// state | meaning
// ------+-------------------------------------------------------------
// FETCH | issuing byte requests and collecting returned bytes
// HOLD  | instruction complete, waiting for stall[0] to release it
module if_fetch
   import if_fetch_pkg::*;
#(
   parameter inst_addr_t RESET_PC = 32'h0000_0000
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [5:0]      stall,
   input  logic            branch_flag_i,
   input  inst_addr_t      branch_target_i,
   if_fetch_mem_if.master  mem,
   output logic            get_inst,
   output inst_addr_t      if_pc,
   output inst_t           if_inst
);

   fetch_state_t state;
   logic [2:0]   req_cnt;
   logic [1:0]   rcv_cnt;
   logic         pending;
   logic         granted;
   logic         accept;
   logic         unused_stall;

   assign unused_stall = &{1'b0, stall[5:1]};

   // Request and address are driven combinationally from the counters so a
   // grant advances to the next byte address without a bubble cycle.
   always_comb begin
      mem.if_mem_req  = 1'b0;
      mem.if_mem_addr = ZERO_WORD;
      if (rst != RST_ENABLE) begin
         mem.if_mem_addr = if_pc + {29'd0, req_cnt};
         if ((state == FETCH) && (req_cnt < BYTES_PER_INST)) begin
            mem.if_mem_req = 1'b1;
         end
      end
   end

   assign granted = mem.if_mem_req & mem.mem_if_grant;
   assign accept  = get_inst & (stall[0] == NO_STOP);

   always_ff @(posedge clk) begin
      if (rst == RST_ENABLE) begin
         state    <= FETCH;
         req_cnt  <= 3'd0;
         rcv_cnt  <= 2'd0;
         pending  <= 1'b0;
         get_inst <= 1'b0;
         if_pc    <= RESET_PC;
         if_inst  <= ZERO_WORD;
      end else if (branch_flag_i) begin
         // Clearing pending drops the byte of any request already granted.
         state    <= FETCH;
         req_cnt  <= 3'd0;
         rcv_cnt  <= 2'd0;
         pending  <= 1'b0;
         get_inst <= 1'b0;
         if_pc    <= branch_target_i;
      end else if (accept) begin
         state    <= FETCH;
         req_cnt  <= 3'd0;
         rcv_cnt  <= 2'd0;
         pending  <= 1'b0;
         get_inst <= 1'b0;
         if_pc    <= if_pc + 32'd4;
      end else if (state == FETCH) begin
         pending <= granted;
         if (granted) begin
            req_cnt <= req_cnt + 3'd1;
         end
         if (pending) begin
            if_inst[{rcv_cnt, 3'b000} +: 8] <= mem.mem_if_data;
            rcv_cnt                         <= rcv_cnt + 2'd1;
            if (rcv_cnt == 2'd3) begin
               state    <= HOLD;
               get_inst <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_if_fetch.sv
// Directed self-checking bench for if_fetch with a byte-wide memory model.
module tb_if_fetch;
   import if_fetch_pkg::*;

   logic       clk;
   logic       rst;
   logic [5:0] stall;
   logic       branch_flag_i;
   inst_addr_t branch_target_i;
   logic       get_inst;
   inst_addr_t if_pc;
   inst_t      if_inst;

   int checks   = 0;
   int failures = 0;

   byte_t memory [0:511];

   if_fetch_mem_if mem ();

   if_fetch #(.RESET_PC(32'h0000_0000)) dut (
      .clk             (clk),
      .rst             (rst),
      .stall           (stall),
      .branch_flag_i   (branch_flag_i),
      .branch_target_i (branch_target_i),
      .mem             (mem),
      .get_inst        (get_inst),
      .if_pc           (if_pc),
      .if_inst         (if_inst)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Returns the addressed byte one cycle after a granted request, junk otherwise.
   always @(posedge clk) begin
      if (mem.if_mem_req && mem.mem_if_grant)
         mem.mem_if_data <= memory[mem.if_mem_addr[8:0]];
      else
         mem.mem_if_data <= 8'hA5;
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step(2);
      checks++; if (get_inst !== 1'b0) begin failures++; $display("FAIL reset_get_inst got=%0b exp=0", get_inst); end
      checks++; if (if_pc !== 32'h0) begin failures++; $display("FAIL reset_if_pc got=%h exp=00000000", if_pc); end
      checks++; if (if_inst !== 32'h0) begin failures++; $display("FAIL reset_if_inst got=%h exp=00000000", if_inst); end
      checks++; if (mem.if_mem_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%0b exp=0", mem.if_mem_req); end
      checks++; if (mem.if_mem_addr !== 32'h0) begin failures++; $display("FAIL reset_addr got=%h exp=00000000", mem.if_mem_addr); end
   endtask

   task automatic test_basic_fetch();
      rst = 1'b0;
      #1;
      checks++; if (mem.if_mem_req !== 1'b1 || mem.if_mem_addr !== 32'h0) begin failures++; $display("FAIL c1_req got=%0b/%h exp=1/00000000", mem.if_mem_req, mem.if_mem_addr); end
      step(1);
      checks++; if (mem.if_mem_addr !== 32'h1) begin failures++; $display("FAIL c2_addr got=%h exp=00000001", mem.if_mem_addr); end
      step(3);
      checks++; if (get_inst !== 1'b0 || mem.if_mem_req !== 1'b0) begin failures++; $display("FAIL c5_state got=%0b/%0b exp=0/0", get_inst, mem.if_mem_req); end
      step(1);
      checks++; if (get_inst !== 1'b1) begin failures++; $display("FAIL c6_get_inst got=%0b exp=1", get_inst); end
      checks++; if (if_pc !== 32'h0) begin failures++; $display("FAIL c6_if_pc got=%h exp=00000000", if_pc); end
      checks++; if (if_inst !== 32'h0010_0513) begin failures++; $display("FAIL c6_if_inst got=%h exp=00100513", if_inst); end
      step(1);
      checks++; if (get_inst !== 1'b0 || if_pc !== 32'h4 || mem.if_mem_addr !== 32'h4) begin failures++; $display("FAIL c7_accept got=%0b/%h/%h exp=0/00000004/00000004", get_inst, if_pc, mem.if_mem_addr); end
      step(4);
      checks++; if (get_inst !== 1'b0) begin failures++; $display("FAIL c11_get_inst got=%0b exp=0", get_inst); end
      step(1);
      checks++; if (get_inst !== 1'b1 || if_pc !== 32'h4 || if_inst !== 32'h0020_0593) begin failures++; $display("FAIL c12_inst got=%0b/%h/%h exp=1/00000004/00200593", get_inst, if_pc, if_inst); end
   endtask

   task automatic test_stall();
      stall = 6'b000001;
      for (int i = 0; i < 3; i++) begin
         step(1);
         checks++; if (get_inst !== 1'b1 || if_pc !== 32'h4 || if_inst !== 32'h0020_0593 || mem.if_mem_req !== 1'b0) begin
            failures++; $display("FAIL stall_hold[%0d] got=%0b/%h/%h/%0b exp=1/00000004/00200593/0", i, get_inst, if_pc, if_inst, mem.if_mem_req);
         end
      end
      stall = 6'b000000;
      step(1);
      checks++; if (get_inst !== 1'b0 || if_pc !== 32'h8 || mem.if_mem_req !== 1'b1) begin failures++; $display("FAIL stall_release got=%0b/%h/%0b exp=0/00000008/1", get_inst, if_pc, mem.if_mem_req); end
   endtask

   task automatic test_grant_gap();
      step(2);
      checks++; if (mem.if_mem_addr !== 32'hA || mem.if_mem_req !== 1'b1) begin failures++; $display("FAIL gap_d3_addr got=%h/%0b exp=0000000a/1", mem.if_mem_addr, mem.if_mem_req); end
      mem.mem_if_grant = 1'b0;
      step(1);
      checks++; if (mem.if_mem_addr !== 32'hA) begin failures++; $display("FAIL gap_d4_addr got=%h exp=0000000a", mem.if_mem_addr); end
      step(1);
      checks++; if (mem.if_mem_addr !== 32'hA) begin failures++; $display("FAIL gap_d5_addr got=%h exp=0000000a", mem.if_mem_addr); end
      mem.mem_if_grant = 1'b1;
      step(2);
      checks++; if (get_inst !== 1'b0) begin failures++; $display("FAIL gap_d7_get_inst got=%0b exp=0", get_inst); end
      step(1);
      checks++; if (get_inst !== 1'b1 || if_pc !== 32'h8 || if_inst !== 32'hC8C9_CACB) begin failures++; $display("FAIL gap_d8_inst got=%0b/%h/%h exp=1/00000008/c8c9cacb", get_inst, if_pc, if_inst); end
   endtask

   task automatic test_branch();
      step(1);
      checks++; if (if_pc !== 32'hC) begin failures++; $display("FAIL br_start_pc got=%h exp=0000000c", if_pc); end
      step(3);
      branch_flag_i   = 1'b1;
      branch_target_i = 32'h0000_0100;
      step(1);
      branch_flag_i = 1'b0;
      checks++; if (mem.if_mem_req !== 1'b1 || mem.if_mem_addr !== 32'h100 || get_inst !== 1'b0) begin failures++; $display("FAIL br_first_req got=%0b/%h/%0b exp=1/00000100/0", mem.if_mem_req, mem.if_mem_addr, get_inst); end
      step(4);
      checks++; if (get_inst !== 1'b0) begin failures++; $display("FAIL br_early_get_inst got=%0b exp=0", get_inst); end
      step(1);
      checks++; if (get_inst !== 1'b1 || if_pc !== 32'h100 || if_inst !== 32'hDEAD_BEEF) begin failures++; $display("FAIL br_inst got=%0b/%h/%h exp=1/00000100/deadbeef", get_inst, if_pc, if_inst); end
   endtask

   task automatic test_branch_over_accept();
      branch_flag_i   = 1'b1;
      branch_target_i = 32'h0000_0004;
      step(1);
      branch_flag_i = 1'b0;
      checks++; if (if_pc !== 32'h4 || get_inst !== 1'b0 || mem.if_mem_addr !== 32'h4) begin failures++; $display("FAIL br_accept got=%h/%0b/%h exp=00000004/0/00000004", if_pc, get_inst, mem.if_mem_addr); end
   endtask

   task automatic test_reset_mid_fetch();
      step(2);
      rst = 1'b1;
      step(1);
      checks++; if (get_inst !== 1'b0 || if_pc !== 32'h0 || if_inst !== 32'h0 || mem.if_mem_req !== 1'b0 || mem.if_mem_addr !== 32'h0) begin
         failures++; $display("FAIL mid_reset got=%0b/%h/%h/%0b/%h exp=0/00000000/00000000/0/00000000", get_inst, if_pc, if_inst, mem.if_mem_req, mem.if_mem_addr);
      end
      rst = 1'b0;
      #1;
      checks++; if (mem.if_mem_req !== 1'b1 || mem.if_mem_addr !== 32'h0) begin failures++; $display("FAIL post_reset_req got=%0b/%h exp=1/00000000", mem.if_mem_req, mem.if_mem_addr); end
      step(5);
      checks++; if (get_inst !== 1'b1 || if_pc !== 32'h0 || if_inst !== 32'h0010_0513) begin failures++; $display("FAIL post_reset_inst got=%0b/%h/%h exp=1/00000000/00100513", get_inst, if_pc, if_inst); end
   endtask

   initial begin
      for (int i = 0; i < 512; i++) memory[i] = 8'(i) ^ 8'hC3;
      memory[0] = 8'h13; memory[1] = 8'h05; memory[2] = 8'h10; memory[3] = 8'h00;
      memory[4] = 8'h93; memory[5] = 8'h05; memory[6] = 8'h20; memory[7] = 8'h00;
      memory[256] = 8'hEF; memory[257] = 8'hBE; memory[258] = 8'hAD; memory[259] = 8'hDE;

      rst              = 1'b1;
      stall            = 6'b000000;
      branch_flag_i    = 1'b0;
      branch_target_i  = 32'h0;
      mem.mem_if_grant = 1'b1;

      test_reset();
      test_basic_fetch();
      test_stall();
      test_grant_gap();
      test_branch();
      test_branch_over_accept();
      test_reset_mid_fetch();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
